// File: rtl/systolic_seq_ctrl.sv
// Operand-feed sequencer for an N x N output-stationary systolic MAC array.
// Clears the PEs, streams skewed per-lane k indices, then pulses done.
module systolic_seq_ctrl #(
  parameter int N     = 4,
  parameter int K_MAX = 16,
  parameter int IW    = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  parameter int CW    = $clog2(K_MAX + 1)
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic [CW-1:0]   cfg_k,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  output logic            pe_clear,
  output logic [N-1:0]    a_vld,
  output logic [N*IW-1:0] a_idx,
  output logic [N-1:0]    b_vld,
  output logic [N*IW-1:0] b_idx
);

  // Handshake: start is a level request with no ready signal. It is taken only
  // on an edge where the FSM sits in IDLE; busy covers CLEAR..DONE, during which
  // start is ignored and never queued. done is a one-cycle pulse and res_valid
  // holds until the next accepted start.
  localparam int TW = $clog2(K_MAX + 2*N - 2);

  typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   k_lat;
  logic [CW-1:0]   k_clamped;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_next;
  logic [TW-1:0]   t_last;
  logic [TW-1:0]   lane_diff;
  logic [N-1:0]    vld_n;
  logic [N*IW-1:0] idx_n;

  assign k_clamped = (cfg_k > CW'(K_MAX)) ? CW'(K_MAX) : cfg_k;
  assign t_last    = TW'(k_lat) + TW'(2*N - 3);
  assign t_next    = (state == FEED) ? t + 1'b1 : '0;

  // Row and column lanes share one skew schedule: lane i lags by i cycles.
  always_comb begin
    vld_n     = '0;
    idx_n     = '0;
    lane_diff = '0;
    for (int i = 0; i < N; i++) begin
      lane_diff = t_next - TW'(i);
      if ((t_next >= TW'(i)) && (lane_diff < TW'(k_lat))) begin
        vld_n[i]            = 1'b1;
        idx_n[i*IW +: IW]   = lane_diff[IW-1:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      k_lat     <= '0;
      t         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_valid <= 1'b0;
      pe_clear  <= 1'b0;
      a_vld     <= '0;
      a_idx     <= '0;
      b_vld     <= '0;
      b_idx     <= '0;
    end else begin
      pe_clear <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_lat     <= k_clamped;
            res_valid <= 1'b0;
            pe_clear  <= 1'b1;
            busy      <= 1'b1;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (k_lat != '0) begin
            state <= FEED;
            t     <= t_next;
            a_vld <= vld_n;
            a_idx <= idx_n;
            b_vld <= vld_n;
            b_idx <= idx_n;
          end else begin
            state     <= DONE;
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        FEED: begin
          if (t == t_last) begin
            state     <= DONE;
            done      <= 1'b1;
            res_valid <= 1'b1;
            a_vld     <= '0;
            a_idx     <= '0;
            b_vld     <= '0;
            b_idx     <= '0;
          end else begin
            t     <= t_next;
            a_vld <= vld_n;
            a_idx <= idx_n;
            b_vld <= vld_n;
            b_idx <= idx_n;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: drives runs against a behavioural PE array and
// scores lane schedules, latency and final dot products.
module tb_systolic_seq_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 16;
  localparam int IW    = 4;
  localparam int CW    = 5;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            start = 1'b0;
  logic [CW-1:0]   cfg_k = '0;
  logic            busy, done, res_valid, pe_clear;
  logic [N-1:0]    a_vld, b_vld;
  logic [N*IW-1:0] a_idx, b_idx;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  logic [31:0] mat_a [N][K_MAX];
  logic [31:0] mat_b [K_MAX][N];
  logic [31:0] ip_left [N];
  logic [31:0] ip_up [N];
  logic [63:0] acc [N][N];
  logic [31:0] ah [N][N];
  logic [31:0] bv [N][N];
  logic [31:0] a_in, b_in;

  systolic_seq_ctrl #(.N(N), .K_MAX(K_MAX), .IW(IW), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .cfg_k(cfg_k),
    .busy(busy), .done(done), .res_valid(res_valid), .pe_clear(pe_clear),
    .a_vld(a_vld), .a_idx(a_idx), .b_vld(b_vld), .b_idx(b_idx)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // top-level operand muxes with zero injection
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ip_left[i] = a_vld[i] ? mat_a[i][a_idx[i*IW +: IW]] : 32'd0;
      ip_up[i]   = b_vld[i] ? mat_b[b_idx[i*IW +: IW]][i] : 32'd0;
    end
  end

  // output-stationary PE array, accumulating unconditionally every cycle
  always @(posedge Clk or posedge Reset) begin
    if (Reset || pe_clear) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          acc[r][c] <= 64'd0;
          ah[r][c]  <= 32'd0;
          bv[r][c]  <= 32'd0;
        end
    end else begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (c == 0) a_in = ip_left[r]; else a_in = ah[r][c-1];
          if (r == 0) b_in = ip_up[c];   else b_in = bv[r-1][c];
          ah[r][c]  <= a_in;
          bv[r][c]  <= b_in;
          acc[r][c] <= acc[r][c] + 64'(a_in) * 64'(b_in);
        end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_bus();
    return 64'({busy, done, res_valid, pe_clear, a_vld, b_vld, a_idx, b_idx});
  endfunction

  // lane schedule re-derived from the skew rule for FEED cycle t
  function automatic void lanes(input int t, input int k,
                                output logic [N-1:0] v, output logic [N*IW-1:0] idx);
    v = '0;
    idx = '0;
    for (int r = 0; r < N; r++)
      if (t >= r && (t - r) < k) begin
        v[r] = 1'b1;
        idx[r*IW +: IW] = IW'(t - r);
      end
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K_MAX; k++) begin
        mat_a[r][k] = $urandom;
        mat_b[k][r] = $urandom;
      end
  endtask

  // One full run: push expected results, accept start, score every cycle to done.
  task automatic run(input int k, input bit hold, input bit pulse);
    int keff, n;
    bit seen;
    logic [63:0] s;
    logic [N-1:0] ev;
    logic [N*IW-1:0] ei;
    keff = (k > K_MAX) ? K_MAX : k;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 64'd0;
        for (int kk = 0; kk < keff; kk++) s = s + 64'(mat_a[r][kk]) * 64'(mat_b[kk][c]);
        exp_q.push_back(s);
      end
    start = 1'b1;
    cfg_k = CW'(k);
    tick();
    if (!hold) start = 1'b0;
    cfg_k = CW'($urandom_range(0, 31));
    chk("clear_pe_clear", 64'(pe_clear), 64'(1));
    chk("clear_busy", 64'(busy), 64'(1));
    chk("clear_res_valid", 64'(res_valid), 64'(0));
    chk("clear_lanes", 64'({a_vld, b_vld}), 64'(0));
    n = 1;
    seen = 1'b0;
    while (n < 100) begin
      if (pulse && n == 5) start = 1'b1;
      if (pulse && n == 6) start = 1'b0;
      tick();
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      lanes(n - 2, keff, ev, ei);
      chk("feed_a_vld", 64'(a_vld), 64'(ev));
      chk("feed_b_vld", 64'(b_vld), 64'(ev));
      chk("feed_a_idx", 64'(a_idx), 64'(ei));
      chk("feed_b_idx", 64'(b_idx), 64'(ei));
      chk("feed_ctrl", 64'({busy, res_valid, pe_clear}), 64'(3'b100));
      if (k == 4 && n - 2 == 3) begin
        chk("t3_a_vld", 64'(a_vld), 64'(4'b1111));
        chk("t3_a_idx", 64'(a_idx), 64'(16'h0123));
      end
      if (k == 4 && n - 2 == 6) begin
        chk("t6_a_vld", 64'(a_vld), 64'(4'b1000));
        chk("t6_a_idx", 64'(a_idx), 64'(16'h3000));
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("done_latency", 64'(n), (keff > 0) ? 64'(keff + 2*N) : 64'(2));
    chk("done_ctrl", 64'({busy, res_valid, pe_clear}), 64'(3'b110));
    chk("done_lanes", 64'({a_vld, b_vld}), 64'(0));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = exp_q.pop_front();
        chk($sformatf("result_%0d_%0d", r, c), acc[r][c], s);
      end
    tick();
    chk("idle_ctrl", 64'({busy, done, res_valid, pe_clear}), 64'(4'b0010));
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K_MAX; k++) begin
        mat_a[r][k] = 32'd0;
        mat_b[k][r] = 32'd0;
      end
    Reset = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", out_bus(), 64'd0);
    Reset = 1'b0;
    tick();
    chk("post_reset_idle", out_bus(), 64'd0);

    // identity operands, K=4; entries past K stay random to expose overreads
    fill_random();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 4; k++) begin
        mat_a[r][k] = (r == k) ? 32'd1 : 32'd0;
        mat_b[k][r] = (r == k) ? 32'd1 : 32'd0;
      end
    run(4, 1'b0, 1'b0);

    // K=0 and clamped K
    fill_random();
    run(0, 1'b0, 1'b0);
    run(K_MAX + 1, 1'b0, 1'b0);
    run(31, 1'b0, 1'b0);

    // start pulsed mid-FEED must not produce a second run
    run(4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_second_done", 64'({done, busy, pe_clear}), 64'(0));
    end

    // start held high: back-to-back runs
    run(3, 1'b1, 1'b0);
    run(5, 1'b0, 1'b0);

    // asynchronous reset in the middle of FEED
    start = 1'b1;
    cfg_k = CW'(8);
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_feed_busy", 64'(busy), 64'(1));
    Reset = 1'b1;
    #1;
    chk("reset_async", out_bus(), 64'd0);
    tick();
    chk("reset_held", out_bus(), 64'd0);
    Reset = 1'b0;
    tick();
    chk("reset_released", out_bus(), 64'd0);
    run(8, 1'b0, 1'b0);

    // random full-depth product
    fill_random();
    run(16, 1'b0, 1'b0);
    fill_random();
    run(7, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
